// File: rtl/mmu_utlb_if.sv
// Pipeline-side and main-TLB-side signal bundle for the micro-TLB front-end.
// Optional UTLB_PERF_CNT_EN adds the per-port hit/miss counter outputs.
interface mmu_utlb_if #(
    parameter int NUM_PORTS = 2,
    parameter int VPN_W     = 20,
    parameter int PFN_W     = 20,
    parameter int ASID_W    = 8
);
    logic [ASID_W-1:0]          asid;
    logic                       flush;
    logic [NUM_PORTS-1:0]       req_valid;
    logic [NUM_PORTS*VPN_W-1:0] req_vpn;
    logic [NUM_PORTS-1:0]       req_ready;
    logic [NUM_PORTS-1:0]       resp_valid;
    logic [NUM_PORTS-1:0]       resp_miss;
    logic [NUM_PORTS*PFN_W-1:0] resp_pfn;
    logic [NUM_PORTS*5-1:0]     resp_flags;
    logic                       tlb_req_valid;
    logic [VPN_W-1:0]           tlb_req_vpn;
    logic                       tlb_resp_valid;
    logic                       tlb_resp_miss;
    logic                       tlb_resp_global;
    logic [PFN_W-1:0]           tlb_resp_pfn;
    logic [4:0]                 tlb_resp_flags;
`ifdef UTLB_PERF_CNT_EN
    logic [NUM_PORTS*32-1:0]    perf_hit;
    logic [NUM_PORTS*32-1:0]    perf_miss;
`endif

    modport slave (
        input  asid, flush, req_valid, req_vpn,
        input  tlb_resp_valid, tlb_resp_miss, tlb_resp_global, tlb_resp_pfn, tlb_resp_flags,
        output req_ready, resp_valid, resp_miss, resp_pfn, resp_flags,
`ifdef UTLB_PERF_CNT_EN
        output perf_hit, perf_miss,
`endif
        output tlb_req_valid, tlb_req_vpn
    );

    modport master (
        output asid, flush, req_valid, req_vpn,
        output tlb_resp_valid, tlb_resp_miss, tlb_resp_global, tlb_resp_pfn, tlb_resp_flags,
        input  req_ready, resp_valid, resp_miss, resp_pfn, resp_flags,
`ifdef UTLB_PERF_CNT_EN
        input  perf_hit, perf_miss,
`endif
        input  tlb_req_valid, tlb_req_vpn
    );
endinterface

// File: rtl/mmu_utlb.sv
// Multi-port micro-TLB: per-port fully-associative caches refilled through one
// round-robin arbitrated main-TLB port. Define UTLB_PERF_CNT_EN for hit/miss counters.
module mmu_utlb #(
    parameter int NUM_PORTS  = 2,
    parameter int UTLB_DEPTH = 4,
    parameter int VPN_W      = 20,
    parameter int PFN_W      = 20,
    parameter int ASID_W     = 8
) (
    input logic         clk,
    input logic         reset,
    mmu_utlb_if.slave   bus
);
    localparam int IDX_W = $clog2(UTLB_DEPTH);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_GRANT, WAIT_RESP} state_e;

    state_e                  st_q [NUM_PORTS];
    state_e                  st_d [NUM_PORTS];
    logic [UTLB_DEPTH-1:0]   v_q  [NUM_PORTS];
    logic [UTLB_DEPTH-1:0]   g_q  [NUM_PORTS];
    logic [VPN_W-1:0]        vpn_q  [NUM_PORTS][UTLB_DEPTH];
    logic [ASID_W-1:0]       asid_q [NUM_PORTS][UTLB_DEPTH];
    logic [PFN_W-1:0]        pfn_q  [NUM_PORTS][UTLB_DEPTH];
    logic [4:0]              flg_q  [NUM_PORTS][UTLB_DEPTH];
    logic [IDX_W-1:0]        rr_q   [NUM_PORTS];
    logic [VPN_W-1:0]        lvpn_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]    stale_q;
    logic [PTR_W-1:0]        arb_q;

    logic [NUM_PORTS-1:0]       resp_valid_q, resp_miss_q;
    logic [NUM_PORTS*PFN_W-1:0] resp_pfn_q;
    logic [NUM_PORTS*5-1:0]     resp_flags_q;
    logic                       tlb_req_valid_q;
    logic [VPN_W-1:0]           tlb_req_vpn_q;

    logic [NUM_PORTS-1:0] hit, acc_hit, acc_miss, rsp_done, fill, full, gnt_oh;
    logic [IDX_W-1:0]     hit_idx [NUM_PORTS];
    logic [IDX_W-1:0]     victim  [NUM_PORTS];
    logic                 gnt_vld, any_wresp;
    logic [PTR_W-1:0]     gnt_idx;

    always_comb begin
        hit = '0; acc_hit = '0; acc_miss = '0; rsp_done = '0; fill = '0; full = '0;
        gnt_oh = '0; gnt_vld = 1'b0; gnt_idx = '0; any_wresp = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            hit_idx[p] = '0;
            victim[p]  = rr_q[p];
            full[p]    = &v_q[p];
            st_d[p]    = st_q[p];
            // Descending scans leave the lowest matching / lowest free index selected
            for (int i = UTLB_DEPTH - 1; i >= 0; i--) begin
                if (v_q[p][i] && vpn_q[p][i] == bus.req_vpn[p*VPN_W +: VPN_W] &&
                    (g_q[p][i] || asid_q[p][i] == bus.asid)) begin
                    hit[p]     = 1'b1;
                    hit_idx[p] = IDX_W'(i);
                end
                if (!v_q[p][i]) victim[p] = IDX_W'(i);
            end
            acc_hit[p]  = bus.req_valid[p] && st_q[p] == IDLE && hit[p] && !bus.flush;
            acc_miss[p] = bus.req_valid[p] && st_q[p] == IDLE && !(hit[p] && !bus.flush);
            rsp_done[p] = st_q[p] == WAIT_RESP && bus.tlb_resp_valid;
            fill[p]     = rsp_done[p] && !bus.tlb_resp_miss && !stale_q[p] && !bus.flush;
            any_wresp   = any_wresp | (st_q[p] == WAIT_RESP);
        end
        // Only one lookup may be outstanding; search starts after the last grant
        if (!any_wresp) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!gnt_vld && st_q[(int'(arb_q) + 1 + i) % NUM_PORTS] == WAIT_GRANT) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'((int'(arb_q) + 1 + i) % NUM_PORTS);
                    gnt_oh[(int'(arb_q) + 1 + i) % NUM_PORTS] = 1'b1;
                end
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            case (st_q[p])
                IDLE:       if (acc_miss[p]) st_d[p] = WAIT_GRANT;
                WAIT_GRANT: if (gnt_oh[p])   st_d[p] = WAIT_RESP;
                WAIT_RESP:  if (rsp_done[p]) st_d[p] = IDLE;
                default:    st_d[p] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                st_q[p] <= IDLE;
                v_q[p]  <= '0;
                rr_q[p] <= '0;
            end
            stale_q         <= '0;
            arb_q           <= '0;
            resp_valid_q    <= '0;
            resp_miss_q     <= '0;
            resp_pfn_q      <= '0;
            resp_flags_q    <= '0;
            tlb_req_valid_q <= 1'b0;
            tlb_req_vpn_q   <= '0;
        end else begin
            tlb_req_valid_q <= gnt_vld;
            if (gnt_vld) begin
                arb_q         <= gnt_idx;
                tlb_req_vpn_q <= lvpn_q[gnt_idx];
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                st_q[p]         <= st_d[p];
                resp_valid_q[p] <= acc_hit[p] | rsp_done[p];
                if (acc_hit[p]) begin
                    resp_miss_q[p]           <= 1'b0;
                    resp_pfn_q[p*PFN_W +: PFN_W] <= pfn_q[p][hit_idx[p]];
                    resp_flags_q[p*5 +: 5]   <= flg_q[p][hit_idx[p]];
                end else if (rsp_done[p]) begin
                    resp_miss_q[p]           <= bus.tlb_resp_miss;
                    resp_pfn_q[p*PFN_W +: PFN_W] <= bus.tlb_resp_pfn;
                    resp_flags_q[p*5 +: 5]   <= bus.tlb_resp_flags;
                end
                if (bus.flush)  v_q[p] <= '0;
                else if (fill[p]) v_q[p][victim[p]] <= 1'b1;
                if (fill[p] && full[p]) rr_q[p] <= rr_q[p] + IDX_W'(1);
                // A flush seen while the lookup is in flight makes its result untrustworthy
                if (gnt_oh[p]) stale_q[p] <= 1'b0;
                else if (st_q[p] == WAIT_RESP && bus.flush) stale_q[p] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc_miss[p]) lvpn_q[p] <= bus.req_vpn[p*VPN_W +: VPN_W];
            if (fill[p]) begin
                vpn_q[p][victim[p]]  <= lvpn_q[p];
                asid_q[p][victim[p]] <= bus.asid;
                g_q[p][victim[p]]    <= bus.tlb_resp_global;
                pfn_q[p][victim[p]]  <= bus.tlb_resp_pfn;
                flg_q[p][victim[p]]  <= bus.tlb_resp_flags;
            end
        end
    end

`ifdef UTLB_PERF_CNT_EN
    logic [31:0] perf_hit_q  [NUM_PORTS];
    logic [31:0] perf_miss_q [NUM_PORTS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                perf_hit_q[p]  <= '0;
                perf_miss_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (acc_hit[p] && perf_hit_q[p] != '1)   perf_hit_q[p]  <= perf_hit_q[p] + 32'd1;
                if (acc_miss[p] && perf_miss_q[p] != '1) perf_miss_q[p] <= perf_miss_q[p] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.perf_hit[p*32 +: 32]  = perf_hit_q[p];
            bus.perf_miss[p*32 +: 32] = perf_miss_q[p];
        end
    end
`endif

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) bus.req_ready[p] = (st_q[p] == IDLE);
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_miss     = resp_miss_q;
    assign bus.resp_pfn      = resp_pfn_q;
    assign bus.resp_flags    = resp_flags_q;
    assign bus.tlb_req_valid = tlb_req_valid_q;
    assign bus.tlb_req_vpn   = tlb_req_vpn_q;
endmodule

// File: tb/tb_mmu_utlb.sv
// Directed scoreboard bench for mmu_utlb with a behavioural main-TLB responder.
module tb_mmu_utlb;
    localparam int NP = 2, D = 4, VW = 20, PW = 20, AW = 8;

    typedef struct packed {
        logic          miss;
        logic [PW-1:0] pfn;
        logic [4:0]    flags;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mmu_utlb_if #(.NUM_PORTS(NP), .VPN_W(VW), .PFN_W(PW), .ASID_W(AW)) bus ();
    mmu_utlb #(.NUM_PORTS(NP), .UTLB_DEPTH(D), .VPN_W(VW), .PFN_W(PW), .ASID_W(AW))
        dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t          sbq0[$];
    exp_t          sbq1[$];
    logic [VW-1:0] treq_log[$];
    logic [PW-1:0] mt_pfn   [logic [VW-1:0]];
    logic [4:0]    mt_flags [logic [VW-1:0]];
    logic          mt_g     [logic [VW-1:0]];
    int ntot = 0, npass = 0, cyc = 0;
    int resp_cnt[NP];
    int last_resp_cyc[NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    endtask

    task automatic set_mt(input logic [VW-1:0] v, input logic [PW-1:0] pfn,
                          input logic [4:0] fl, input logic g);
        mt_pfn[v] = pfn; mt_flags[v] = fl; mt_g[v] = g;
    endtask

    function automatic exp_t mt_expect(input logic [VW-1:0] v);
        exp_t e;
        if (mt_pfn.exists(v)) begin e.miss = 1'b0; e.pfn = mt_pfn[v]; e.flags = mt_flags[v]; end
        else begin e.miss = 1'b1; e.pfn = '0; e.flags = '0; end
        return e;
    endfunction

    task automatic push_exp(input int p, input exp_t e);
        if (p == 0) sbq0.push_back(e); else sbq1.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor: pops the scoreboard on every response pulse
    initial begin
        exp_t e;
        for (int p = 0; p < NP; p++) begin resp_cnt[p] = 0; last_resp_cyc[p] = 0; end
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (bus.resp_valid[p]) begin
                    resp_cnt[p]++;
                    last_resp_cyc[p] = cyc;
                    if ((p == 0 && sbq0.size() == 0) || (p == 1 && sbq1.size() == 0)) begin
                        chk($sformatf("resp_unexpected_p%0d", p), 1, 0);
                    end else begin
                        e = (p == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        chk($sformatf("resp_miss_p%0d", p), bus.resp_miss[p], e.miss);
                        chk($sformatf("resp_pfn_p%0d", p), bus.resp_pfn[p*PW +: PW], e.pfn);
                        chk($sformatf("resp_flags_p%0d", p), bus.resp_flags[p*5 +: 5], e.flags);
                    end
                end
            end
        end
    end

    // Main-TLB model: answers two cycles after each lookup request
    initial begin
        logic [VW-1:0] rv;
        bus.tlb_resp_valid = 1'b0; bus.tlb_resp_miss = 1'b0; bus.tlb_resp_global = 1'b0;
        bus.tlb_resp_pfn = '0; bus.tlb_resp_flags = '0;
        forever begin
            @(negedge clk);
            if (bus.tlb_req_valid) begin
                rv = bus.tlb_req_vpn;
                treq_log.push_back(rv);
                @(negedge clk);
                chk("tlb_req_one_cycle", bus.tlb_req_valid, 0);
                @(posedge clk); #1;
                bus.tlb_resp_valid = 1'b1;
                if (mt_pfn.exists(rv)) begin
                    bus.tlb_resp_miss = 1'b0; bus.tlb_resp_pfn = mt_pfn[rv];
                    bus.tlb_resp_flags = mt_flags[rv]; bus.tlb_resp_global = mt_g[rv];
                end else begin
                    bus.tlb_resp_miss = 1'b1; bus.tlb_resp_pfn = '0;
                    bus.tlb_resp_flags = '0; bus.tlb_resp_global = 1'b0;
                end
                @(posedge clk); #1;
                bus.tlb_resp_valid = 1'b0; bus.tlb_resp_miss = 1'b0;
                bus.tlb_resp_pfn = '0; bus.tlb_resp_flags = '0; bus.tlb_resp_global = 1'b0;
            end
        end
    end

    task automatic lookup(input int p, input logic [VW-1:0] vpn, input bit exp_hit,
                          input bit with_flush, input string tag);
        int n0, r0, t0, k;
        k = 0;
        while (!bus.req_ready[p] && k < 50) begin @(posedge clk); #1; k++; end
        chk({tag, "_ready"}, bus.req_ready[p], 1);
        push_exp(p, mt_expect(vpn));
        n0 = treq_log.size(); r0 = resp_cnt[p]; t0 = cyc;
        bus.req_valid[p] = 1'b1;
        bus.req_vpn[p*VW +: VW] = vpn;
        bus.flush = with_flush;
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        bus.flush = 1'b0;
        k = 0;
        while (resp_cnt[p] == r0 && k < 50) begin @(posedge clk); #1; k++; end
        chk({tag, "_resp"}, resp_cnt[p] - r0, 1);
        chk({tag, "_tlbreq"}, treq_log.size() - n0, exp_hit ? 0 : 1);
        if (exp_hit) chk({tag, "_lat"}, last_resp_cyc[p] - t0, 1);
    endtask

    task automatic lookup_pair(input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                               input logic [VW-1:0] first, input string tag);
        int n0, r0, r1, k;
        push_exp(0, mt_expect(v0));
        push_exp(1, mt_expect(v1));
        n0 = treq_log.size(); r0 = resp_cnt[0]; r1 = resp_cnt[1];
        bus.req_valid = 2'b11;
        bus.req_vpn[0 +: VW] = v0;
        bus.req_vpn[VW +: VW] = v1;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        k = 0;
        while ((resp_cnt[0] == r0 || resp_cnt[1] == r1) && k < 100) begin @(posedge clk); #1; k++; end
        chk({tag, "_resp0"}, resp_cnt[0] - r0, 1);
        chk({tag, "_resp1"}, resp_cnt[1] - r1, 1);
        chk({tag, "_tlbreqs"}, treq_log.size() - n0, 2);
        if (treq_log.size() >= n0 + 2) begin
            chk({tag, "_first"}, treq_log[n0], first);
            chk({tag, "_second"}, treq_log[n0+1], (first == v0) ? v1 : v0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, r0, k;
        bus.asid = 8'd5; bus.flush = 1'b0; bus.req_valid = '0; bus.req_vpn = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 2'b11);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_resp_pfn", bus.resp_pfn, 0);
        chk("rst_tlb_req_valid", bus.tlb_req_valid, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Cold miss then immediate hit
        set_mt(20'h12345, 20'h00ABC, 5'b11011, 1'b0);
        lookup(0, 20'h12345, 0, 0, "cold_miss");
        lookup(0, 20'h12345, 1, 0, "cold_rehit");

        // ASID mismatch forces refill; a global entry then hits under the new ASID
        bus.asid = 8'd6;
        set_mt(20'h12345, 20'h00DEF, 5'b10010, 1'b1);
        lookup(0, 20'h12345, 0, 0, "asid6_miss");
        lookup(0, 20'h12345, 1, 0, "global_hit");

        // Port1 refill leaves port1 as the last grant
        set_mt(20'h00100, 20'h11111, 5'b10001, 1'b0);
        lookup(1, 20'h00100, 0, 0, "p1_solo");

        set_mt(20'h00200, 20'h22222, 5'b11000, 1'b0);
        set_mt(20'h00300, 20'h33333, 5'b10100, 1'b0);
        lookup_pair(20'h00200, 20'h00300, 20'h00200, "contend_a");

        // Main-TLB miss is reported and never cached
        lookup(0, 20'h0DEAD, 0, 0, "tlbmiss");
        lookup(0, 20'h0DEAD, 0, 0, "tlbmiss_again");

        set_mt(20'h00400, 20'h44444, 5'b11111, 1'b0);
        set_mt(20'h00500, 20'h55555, 5'b00011, 1'b0);
        lookup_pair(20'h00400, 20'h00500, 20'h00500, "contend_b");

        // Flush in the accept cycle turns a hit into a refill
        lookup(0, 20'h00200, 1, 0, "pre_flush_hit");
        lookup(0, 20'h00200, 0, 1, "flush_accept_miss");
        lookup(0, 20'h00200, 1, 0, "post_refill_hit");

        // Replacement: 5 fills into 4 entries evict entry 0
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_mt(VW'(32'h01000 + i), PW'(32'hA0000 + i), 5'(i), 1'b0);
            lookup(0, VW'(32'h01000 + i), 0, 0, $sformatf("fill_v%0d", i));
        end
        for (int i = 2; i <= 5; i++) lookup(0, VW'(32'h01000 + i), 1, 0, $sformatf("keep_v%0d", i));
        lookup(0, 20'h01001, 0, 0, "evicted_v1");

        // Flush while the refill is in flight: delivered, not installed
        set_mt(20'h02000, 20'h0F0F0, 5'b10110, 1'b0);
        push_exp(0, mt_expect(20'h02000));
        n0 = treq_log.size(); r0 = resp_cnt[0];
        bus.req_valid[0] = 1'b1;
        bus.req_vpn[0 +: VW] = 20'h02000;
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        k = 0;
        while (treq_log.size() == n0 && k < 50) begin @(posedge clk); #1; k++; end
        chk("wresp_flush_tlbreq", treq_log.size() - n0, 1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        k = 0;
        while (resp_cnt[0] == r0 && k < 50) begin @(posedge clk); #1; k++; end
        chk("wresp_flush_resp", resp_cnt[0] - r0, 1);
        lookup(0, 20'h02000, 0, 0, "stale_not_cached");
        lookup(0, 20'h01003, 0, 0, "prior_entry_flushed");
        lookup(1, 20'h00100, 0, 0, "p1_entry_flushed");
        lookup(0, 20'h02000, 1, 0, "refilled_hit");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained_p0", sbq0.size(), 0);
        chk("sb_drained_p1", sbq1.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
